// File: rtl/data_aligner_ctrl.sv
// ---------------------------------------------------------------------------
// data_aligner_ctrl
//
// Purpose:
//   Sequencing controller for the two-stream data aligner. It clears the
//   aligner FIFOs, waits until they have drained, then opens the valid gates
//   of both input streams. Lock is declared after a set number of aligned
//   output words. While the gates are open it watches the imbalance between
//   accepted stream-1 and stream-2 words and the FIFO-full status. On any
//   fault it bumps a saturating error counter and runs a fresh flush/resync.
//
// Ports:
//   clk         in   1          rising-edge clock for all logic
//   aresetn     in   1          synchronous reset, active HIGH despite name
//   enable_i    in   1          run request; low forces IDLE
//   vld_1st_i   in   1          raw stream-1 valid (before gating)
//   vld_2d_i    in   1          raw stream-2 valid (before gating)
//   vld_o_i     in   1          aligner output valid
//   statuses_i  in   2          [1] any FIFO full, [0] both FIFOs empty
//   gate_1st_o  out  1          stream-1 valid enable into the aligner
//   gate_2d_o   out  1          stream-2 valid enable into the aligner
//   flush_o     out  1          aligner FIFO clear
//   aligned_o   out  1          lock indicator
//   err_cnt_o   out  ERR_CNT_W  saturating fault count
//   state_o     out  3          current state encoding
// ---------------------------------------------------------------------------
module data_aligner_ctrl #(
  parameter int MAX_SKEW     = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int LOCK_PAIRS   = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 enable_i,
  input  logic                 vld_1st_i,
  input  logic                 vld_2d_i,
  input  logic                 vld_o_i,
  input  logic [1:0]           statuses_i,
  output logic                 gate_1st_o,
  output logic                 gate_2d_o,
  output logic                 flush_o,
  output logic                 aligned_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [2:0]           state_o
);

  // Imbalance can reach MAX_SKEW+2 in magnitude (fault detected at
  // MAX_SKEW+1, one more word may land before the flush clears it), so the
  // signed register needs room for that plus the sign bit.
  localparam int IMB_W   = $clog2(MAX_SKEW + 2) + 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int PAIR_W  = (LOCK_PAIRS > 1) ? $clog2(LOCK_PAIRS) : 1;

  localparam logic [FLUSH_W-1:0]      FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [PAIR_W-1:0]       PAIR_LAST  = PAIR_W'(LOCK_PAIRS - 1);
  localparam logic signed [IMB_W-1:0] SKEW_POS   = IMB_W'(MAX_SKEW);
  localparam logic signed [IMB_W-1:0] SKEW_NEG   = -SKEW_POS;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH      = 3'd1,
    WAIT_EMPTY = 3'd2,
    SYNC       = 3'd3,
    LOCKED     = 3'd4
  } state_t;

  state_t                   r_state;
  logic                     r_gate;
  logic                     r_flush;
  logic                     r_aligned;
  logic [ERR_CNT_W-1:0]     r_errCnt;
  logic signed [IMB_W-1:0]  r_imb;
  logic [FLUSH_W-1:0]       r_flushCnt;
  logic [PAIR_W-1:0]        r_pairCnt;

  state_t                   w_next;
  logic                     w_acc1;
  logic                     w_acc2;
  logic                     w_active;
  logic                     w_skewFault;
  logic                     w_fullFault;
  logic                     w_fault;
  logic                     w_flushDone;
  logic                     w_lockDone;
  logic                     w_errSat;

  // Words only count once they have actually passed the gate into the
  // aligner. Gates are open exactly in SYNC and LOCKED, which is also the
  // window where faults are monitored.
  assign w_acc1   = vld_1st_i & r_gate;
  assign w_acc2   = vld_2d_i & r_gate;
  assign w_active = (r_state == SYNC) || (r_state == LOCKED);

  // Both fault sources collapse into one event so a double fault only
  // counts once. The skew test uses the registered imbalance.
  assign w_skewFault = (r_imb > SKEW_POS) || (r_imb < SKEW_NEG);
  assign w_fullFault = statuses_i[1];
  assign w_fault     = w_active && (w_skewFault || w_fullFault);

  // The final flush cycle is the one where the counter shows
  // FLUSH_CYCLES-1; lock completes on the pulse that would bring the
  // pair count up to LOCK_PAIRS.
  assign w_flushDone = (r_flushCnt == FLUSH_LAST);
  assign w_lockDone  = vld_o_i && (r_pairCnt == PAIR_LAST);
  assign w_errSat    = &r_errCnt;

  // Next-state selection. Enable drop beats any fault, and a fault beats
  // the normal progression, which is how a fault coinciding with lock
  // completion ends up in FLUSH rather than LOCKED.
  always_comb begin
    w_next = r_state;
    if (!enable_i) begin
      w_next = IDLE;
    end else if (w_fault) begin
      w_next = FLUSH;
    end else begin
      case (r_state)
        IDLE:       w_next = FLUSH;
        FLUSH:      if (w_flushDone) w_next = WAIT_EMPTY;
        WAIT_EMPTY: if (statuses_i[0]) w_next = SYNC;
        SYNC:       if (w_lockDone) w_next = LOCKED;
        LOCKED:     w_next = LOCKED;
        default:    w_next = IDLE;
      endcase
    end
  end

  // State register plus the Moore outputs. The outputs are decoded from
  // the upcoming state and registered alongside it, so they always match
  // r_state and nothing from the inputs reaches the pins in the same cycle.
  always_ff @(posedge clk) begin
    if (aresetn) begin
      r_state   <= IDLE;
      r_flush   <= 1'b0;
      r_gate    <= 1'b0;
      r_aligned <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_flush   <= (w_next == FLUSH);
      r_gate    <= (w_next == SYNC) || (w_next == LOCKED);
      r_aligned <= (w_next == LOCKED);
    end
  end

  // Flush duration counter. It only advances while FLUSH is being held, so
  // every entry into FLUSH (from IDLE or from a fault) starts at zero.
  always_ff @(posedge clk) begin
    if (aresetn) begin
      r_flushCnt <= '0;
    end else if ((r_state == FLUSH) && (w_next == FLUSH)) begin
      r_flushCnt <= r_flushCnt + 1'b1;
    end else begin
      r_flushCnt <= '0;
    end
  end

  // Aligned-pair counter. Counts output valids while SYNC is held and is
  // zero whenever SYNC is left or not occupied, so a resync starts over.
  always_ff @(posedge clk) begin
    if (aresetn) begin
      r_pairCnt <= '0;
    end else if ((r_state == SYNC) && (w_next == SYNC)) begin
      if (vld_o_i) begin
        r_pairCnt <= r_pairCnt + 1'b1;
      end
    end else begin
      r_pairCnt <= '0;
    end
  end

  // Stream imbalance tracker. Outside the gated window it is held at zero;
  // inside it moves by one for each unmatched accepted word.
  always_ff @(posedge clk) begin
    if (aresetn) begin
      r_imb <= '0;
    end else if (!w_active) begin
      r_imb <= '0;
    end else if (w_acc1 && !w_acc2) begin
      r_imb <= r_imb + IMB_W'(1);
    end else if (w_acc2 && !w_acc1) begin
      r_imb <= r_imb - IMB_W'(1);
    end
  end

  // Fault counter. Counts only faults that actually trigger a resync (an
  // enable drop takes priority), and sticks at all-ones until reset.
  always_ff @(posedge clk) begin
    if (aresetn) begin
      r_errCnt <= '0;
    end else if (enable_i && w_fault && !w_errSat) begin
      r_errCnt <= r_errCnt + 1'b1;
    end
  end

  assign gate_1st_o = r_gate;
  assign gate_2d_o  = r_gate;
  assign flush_o    = r_flush;
  assign aligned_o  = r_aligned;
  assign err_cnt_o  = r_errCnt;
  assign state_o    = r_state;

endmodule

// File: doc/data_aligner_ctrl.md
# data_aligner_ctrl

Sequencing controller for the two-stream data aligner. It flushes the aligner FIFOs, waits for them to drain, gates the two input valid streams, and declares lock after a set number of aligned output words. It monitors stream imbalance and FIFO overflow, and runs an automatic flush/resync on any fault. It sits beside the aligner: its gate outputs are ANDed into the aligner's `vld_1st_i`/`vld_2d_i`, and it observes the aligner's `vld_o` and `statuses_o`.

## Interface
Parameters:
- `MAX_SKEW`, 8: largest tolerated |accepted 1st − accepted 2d| word difference.
- `FLUSH_CYCLES`, 4: duration of the `flush_o` assertion, in cycles (≥1).
- `LOCK_PAIRS`, 4: number of `vld_o` pulses required in SYNC to declare lock (≥1).
- `ERR_CNT_W`, 8: width of the error counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  run request; low forces IDLE.
- `vld_1st_i`  in  1  raw valid of stream 1, before gating.
- `vld_2d_i`  in  1  raw valid of stream 2, before gating.
- `vld_o_i`  in  1  aligner output valid.
- `statuses_i`  in  2  aligner FIFO status; [1] = any FIFO full, [0] = both FIFOs empty.
- `gate_1st_o`  out  1  enable for stream 1 valid into aligner.
- `gate_2d_o`  out  1  enable for stream 2 valid into aligner.
- `flush_o`  out  1  aligner FIFO clear.
- `aligned_o`  out  1  lock indicator.
- `err_cnt_o`  out  ERR_CNT_W  saturating fault count.
- `state_o`  out  3  current state encoding.

## Operation
- State encodings: IDLE=0, FLUSH=1, WAIT_EMPTY=2, SYNC=3, LOCKED=4.
- All outputs are Moore outputs, decoded from registers only. There is no combinational input→output path.
- Output decode by state:
  - `flush_o`=1 only in FLUSH.
  - `gate_1st_o` and `gate_2d_o`=1 only in SYNC and LOCKED.
  - `aligned_o`=1 only in LOCKED.
- Accepted words: acc1 = `vld_1st_i` & `gate_1st_o`; acc2 = `vld_2d_i` & `gate_2d_o`.
- Imbalance register `imb`:
  - Signed, width $clog2(MAX_SKEW+2)+1.
  - Cleared in IDLE, FLUSH and WAIT_EMPTY.
  - +1 when acc1 & !acc2; −1 when acc2 & !acc1; held otherwise.
- Fault conditions, evaluated in SYNC and LOCKED on registered values: |imb| > MAX_SKEW, or `statuses_i`[1]=1.
- On a fault: `err_cnt_o` increments by exactly 1, even if both conditions hold together. It saturates at all-ones and is cleared only by reset. Next state is FLUSH.
- Pair counter: cleared outside SYNC; +1 per `vld_o_i` in SYNC.
- Transitions, in priority order: reset > `enable_i`=0 (→IDLE from any state) > fault > normal.
- Normal transitions:
  - IDLE→FLUSH when `enable_i`=1.
  - FLUSH→WAIT_EMPTY after FLUSH_CYCLES cycles.
  - WAIT_EMPTY→SYNC when `statuses_i`[0]=1.
  - SYNC→LOCKED when the pair counter reaches LOCK_PAIRS.
  - LOCKED holds.
- A fault in the same cycle as lock completion wins: next state is FLUSH, not LOCKED.
- A fault arising during FLUSH or WAIT_EMPTY is ignored.

## Timing
- Reset values: state IDLE, `flush_o`=0, gates=0, `aligned_o`=0, `err_cnt_o`=0, `state_o`=0, `imb`=0, all internal counters 0.
- `aresetn` high mid-operation: all of the above reset values appear at the next edge.
- Enable latency: `enable_i` sampled high at edge N gives `flush_o`=1 for exactly cycles N+1 … N+FLUSH_CYCLES. WAIT_EMPTY follows at N+FLUSH_CYCLES+1.
- WAIT_EMPTY exit: `statuses_i`[0] sampled 1 at edge M gives gates=1 from M+1.
- Lock latency: the LOCK_PAIRS-th `vld_o_i`, sampled at edge K, gives `aligned_o`=1 from K+1.
- Fault latency: `imb` registered at MAX_SKEW+1 after edge F gives FLUSH state, gates=0 and `err_cnt_o`+1 at edge F+1.
- Gating consequence: words presented while gates are 0 are not counted and do not reach the aligner.
- `enable_i` low at edge D gives gates=0, `flush_o`=0 and `aligned_o`=0 from D+1. This includes the case where `enable_i` drops mid-FLUSH.

## Test plan
- Basic lock. Defaults; `enable_i`=1; `statuses_i`=01 during WAIT_EMPTY; then 4 cycles of paired valids with `vld_o_i`. Required: `flush_o` high 4 cycles, gates rise one cycle after empty is seen, `aligned_o`=1 one cycle after the 4th `vld_o_i`, `err_cnt_o`=0.
- Skew fault. In LOCKED, drive `vld_1st_i` only for 9 cycles. Required: `imb` reaches 9, then next cycle FLUSH, `err_cnt_o`=1, `aligned_o`=0, gates=0. After the flush, drain and lock again.
- Simultaneous faults. `statuses_i`[1]=1 in the same cycle `imb`=−9. Required: `err_cnt_o` increments by exactly 1; one FLUSH of 4 cycles.
- Lock vs fault race. In SYNC, the 4th `vld_o_i` coincides with `statuses_i`[1]=1. Required: next state FLUSH (`state_o`=1), `aligned_o` stays 0.
- Enable drop and saturation.
  - `enable_i`=0 mid-FLUSH: next cycle IDLE, `flush_o`=0.
  - With ERR_CNT_W=2, force 5 faults: `err_cnt_o` holds at 3.
- Reset mid-LOCKED. Assert `aresetn` for one cycle. Required: all outputs at their reset values next cycle, `err_cnt_o`=0.
